// File: rtl/ir_emitter.sv
// Modulated IR line sensor front end: pulses the emitter once per frame, samples the receivers
// with the emitter lit and dark, rejects ambient light and debounces the per-sensor result.
module ir_emitter #(
    parameter int unsigned ON_CYC    = 2000,
    parameter int unsigned SAMPLE_AT = 1500,
    parameter int unsigned FRAME_CYC = 100000,
    parameter int unsigned DEB       = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [4:0] iSens,
    output logic       oEmit,
    output logic [4:0] oLine,
    output logic [4:0] oAmbErr,
    output logic       oValid
);

    localparam int unsigned CntW = $clog2(FRAME_CYC);
    localparam int unsigned DebW = $clog2(DEB + 1);

    localparam logic [CntW-1:0] LitAt   = CntW'(SAMPLE_AT - 1);
    localparam logic [CntW-1:0] OnLast  = CntW'(ON_CYC - 1);
    localparam logic [CntW-1:0] AmbAt   = CntW'(ON_CYC + SAMPLE_AT - 1);
    localparam logic [CntW-1:0] OffLast = CntW'(FRAME_CYC - 1);
    localparam logic [DebW-1:0] DebLast = DebW'(DEB - 1);

    typedef enum logic [1:0] {StIdle, StOn, StOff, StUpdate} stateT;

    stateT                    stateQ, stateD;
    logic [CntW-1:0]          cntQ, cntD;
    logic [4:0]               syncQ1, syncQ2;
    logic [4:0]               litQ, ambQ;
    logic                     emitQ, validQ;
    logic [4:0]               lineQ, lineD;
    logic [4:0]               ambErrQ;
    logic [4:0][DebW-1:0]     debQ, debD;
    logic [4:0]               det;
    logic                     enterUpd;

    // The result registers load on the edge into UPDATE, so they already hold the new
    // values during the single cycle oValid is high.
    assign enterUpd = (stateQ == StOff) && (cntQ == OffLast);
    assign det      = litQ & ~ambQ;

    always_comb begin
        stateD = stateQ;
        cntD   = cntQ;
        unique case (stateQ)
            StIdle: begin
                cntD = '0;
                if (en) begin
                    stateD = StOn;
                end
            end
            StOn: begin
                cntD = cntQ + CntW'(1);
                if (cntQ == OnLast) begin
                    stateD = StOff;
                end
            end
            StOff: begin
                cntD = cntQ + CntW'(1);
                if (cntQ == OffLast) begin
                    stateD = StUpdate;
                    cntD   = '0;
                end
            end
            StUpdate: begin
                cntD   = '0;
                stateD = en ? StOn : StIdle;
            end
            default: begin
                stateD = StIdle;
                cntD   = '0;
            end
        endcase
    end

    always_comb begin
        debD  = debQ;
        lineD = lineQ;
        if (enterUpd) begin
            for (int i = 0; i < 5; i++) begin
                if (det[i] == lineQ[i]) begin
                    debD[i] = '0;
                end else if (debQ[i] == DebLast) begin
                    lineD[i] = det[i];
                    debD[i]  = '0;
                end else begin
                    debD[i] = debQ[i] + DebW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stateQ  <= StIdle;
            cntQ    <= '0;
            syncQ1  <= '0;
            syncQ2  <= '0;
            litQ    <= '0;
            ambQ    <= '0;
            emitQ   <= 1'b0;
            validQ  <= 1'b0;
            lineQ   <= '0;
            ambErrQ <= '0;
            debQ    <= '0;
        end else begin
            stateQ <= stateD;
            cntQ   <= cntD;
            syncQ1 <= iSens;
            syncQ2 <= syncQ1;
            if (stateQ == StOn && cntQ == LitAt) begin
                litQ <= syncQ2;
            end
            if (stateQ == StOff && cntQ == AmbAt) begin
                ambQ <= syncQ2;
            end
            // Emitter and strobe follow the next state so both come straight from flops.
            emitQ  <= (stateD == StOn);
            validQ <= (stateD == StUpdate);
            lineQ  <= lineD;
            debQ   <= debD;
            if (enterUpd) begin
                ambErrQ <= ambQ;
            end
        end
    end

    assign oEmit   = emitQ;
    assign oValid  = validQ;
    assign oLine   = lineQ;
    assign oAmbErr = ambErrQ;

endmodule

// File: tb/tb_ir_emitter.sv
// Directed bench for ir_emitter with short frames; expected values are hand-derived
// from the frame timing (ON 20, sample 15, frame 100, debounce 3).
module tb_ir_emitter;

    localparam int unsigned OnCyc    = 20;
    localparam int unsigned SampleAt = 15;
    localparam int unsigned FrameCyc = 100;
    localparam int unsigned Deb      = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [4:0] iSens;
    logic       oEmit;
    logic [4:0] oLine;
    logic [4:0] oAmbErr;
    logic       oValid;

    int   total = 0;
    int   bad = 0;
    int   senseMode = 0;
    logic altPhase = 1'b0;

    always #5 clk = ~clk;

    // Sensor model: 1 = reflection only while lit, 2 = constant ambient, 3 = lit on alternate frames.
    assign iSens = (senseMode == 1) ? (oEmit ? 5'b00100 : 5'b00000) :
                   (senseMode == 2) ? 5'b11111 :
                   (senseMode == 3) ? ((oEmit && altPhase) ? 5'b00100 : 5'b00000) :
                   5'b00000;

    ir_emitter #(
        .ON_CYC   (OnCyc),
        .SAMPLE_AT(SampleAt),
        .FRAME_CYC(FrameCyc),
        .DEB      (Deb)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .en     (en),
        .iSens  (iSens),
        .oEmit  (oEmit),
        .oLine  (oLine),
        .oAmbErr(oAmbErr),
        .oValid (oValid)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic doReset();
        en  = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int firstEmit;
        int emitCnt;
        int validCnt;
        int validAt[4];
        int emitAfter;

        // Reset with en high: outputs clear before any clock edge.
        rst = 1'b0;
        en  = 1'b1;
        #2 rst = 1'b1;
        #1;
        check("rstEmit", 32'(oEmit), 32'd0);
        check("rstLine", 32'(oLine), 32'd0);
        check("rstAmb", 32'(oAmbErr), 32'd0);
        check("rstValid", 32'(oValid), 32'd0);
        @(negedge clk);
        en = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        emitCnt  = 0;
        validCnt = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (oEmit) emitCnt++;
            if (oValid) validCnt++;
        end
        check("idleEmit", 32'(emitCnt), 32'd0);
        check("idleValid", 32'(validCnt), 32'd0);

        // Frame timing plus detect/debounce with a reflection only while lit.
        senseMode = 1;
        en        = 1'b1;
        firstEmit = 0;
        emitCnt   = 0;
        validCnt  = 0;
        for (int k = 1; k <= 303; k++) begin
            @(negedge clk);
            if (oEmit && firstEmit == 0) firstEmit = k;
            if (oEmit && k <= 101) emitCnt++;
            if (oValid) begin
                validCnt++;
                if (validCnt <= 3) validAt[validCnt] = k;
                check("detLine", 32'(oLine), (validCnt >= 3) ? 32'h04 : 32'h00);
                check("detAmb", 32'(oAmbErr), 32'd0);
                check("updEmit", 32'(oEmit), 32'd0);
            end
        end
        check("firstEmit", 32'(firstEmit), 32'd1);
        check("emitLen", 32'(emitCnt), 32'd20);
        check("validCnt", 32'(validCnt), 32'd3);
        check("valid1", 32'(validAt[1]), 32'd101);
        check("valid2", 32'(validAt[2]), 32'd202);
        check("valid3", 32'(validAt[3]), 32'd303);
        doReset();

        // Constant ambient light: flagged, never detected.
        senseMode = 2;
        en        = 1'b1;
        validCnt  = 0;
        for (int k = 1; k <= 1010; k++) begin
            @(negedge clk);
            if (oValid) begin
                validCnt++;
                if (validCnt == 1) check("ambErr1", 32'(oAmbErr), 32'h1f);
                check("ambLine", 32'(oLine), 32'd0);
            end
        end
        check("ambFrames", 32'(validCnt), 32'd10);
        doReset();

        // Detect on bit C flips every frame; debounce must hold oLine.
        senseMode = 3;
        altPhase  = 1'b1;
        en        = 1'b1;
        validCnt  = 0;
        for (int k = 1; k <= 1212; k++) begin
            @(negedge clk);
            if (oValid) begin
                validCnt++;
                check("glitchC", 32'(oLine[2]), 32'd0);
                check("glitchAmb", 32'(oAmbErr), 32'd0);
                altPhase = ~altPhase;
            end
        end
        check("glitchFrames", 32'(validCnt), 32'd12);
        senseMode = 0;
        doReset();

        // en dropped at ON cycle 5: frame completes once, then idle.
        en        = 1'b1;
        validCnt  = 0;
        emitCnt   = 0;
        emitAfter = 0;
        validAt[1] = 0;
        for (int k = 1; k <= 300; k++) begin
            @(negedge clk);
            if (k == 6) en = 1'b0;
            if (oEmit) emitCnt++;
            if (oEmit && validCnt > 0) emitAfter++;
            if (oValid) begin
                validCnt++;
                validAt[1] = k;
            end
        end
        check("dropValid", 32'(validCnt), 32'd1);
        check("dropAt", 32'(validAt[1]), 32'd101);
        check("dropEmit", 32'(emitCnt), 32'd20);
        check("dropAfter", 32'(emitAfter), 32'd0);
        doReset();

        // Reset at OFF cycle 40 of frame 2 aborts it without a strobe.
        senseMode = 2;
        en        = 1'b1;
        for (int k = 1; k <= 162; k++) begin
            @(negedge clk);
            if (k == 101) check("preAmb", 32'(oAmbErr), 32'h1f);
        end
        rst = 1'b1;
        #1;
        check("midEmit", 32'(oEmit), 32'd0);
        check("midLine", 32'(oLine), 32'd0);
        check("midAmb", 32'(oAmbErr), 32'd0);
        check("midValid", 32'(oValid), 32'd0);
        @(negedge clk);
        en = 1'b0;
        @(negedge clk);
        rst      = 1'b0;
        validCnt = 0;
        emitCnt  = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (oValid) validCnt++;
            if (oEmit) emitCnt++;
        end
        check("abortValid", 32'(validCnt), 32'd0);
        check("abortEmit", 32'(emitCnt), 32'd0);
        en = 1'b1;
        @(negedge clk);
        check("restart", 32'(oEmit), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ir_emitter.md
IR_EMITTER -- requirements
Module: ir_emitter

Interface
REQ-001 The block SHALL have parameter ON_CYC, default 2000, meaning emitter-on cycles per frame.
REQ-002 The block SHALL have parameter SAMPLE_AT, default 1500, meaning the sample offset in cycles within both the on and off windows.
REQ-003 The block SHALL have parameter FRAME_CYC, default 100000, meaning the cycles from frame start to the UPDATE state.
REQ-004 The block SHALL have parameter DEB, default 3, meaning the consecutive agreeing frames needed to change an output bit.
REQ-005 The block SHALL have one clock; reset is asynchronous and active-high.
REQ-006 The port list SHALL be, in this order:
- clk  in  1  single clock.
- rst  in  1  reset, asynchronous, active-high.
- en  in  1  enables frame generation.
- iSens  in  5  raw sensor receivers {L,LC,C,RC,R}, bit4=L; 1 = reflection seen.
- oEmit  out  1  IR emitter LED drive.
- oLine  out  5  debounced line detect, same bit order as iSens.
- oAmbErr  out  5  sensor saw reflection with emitter off in the last frame.
- oValid  out  1  one-cycle strobe; oLine and oAmbErr updated this cycle.

Function
REQ-007 iSens SHALL pass through a 2-flop synchronizer; "sync" below means its output, i.e. iSens delayed 2 cycles.
REQ-008 The FSM SHALL have states IDLE, ON, OFF and UPDATE, plus a frame counter cnt.
REQ-009 In IDLE: oEmit=0 and cnt=0; en=1 -> ON on the next edge.
REQ-010 In ON: oEmit=1 and cnt increments each cycle.
- cnt==SAMPLE_AT-1 -> lit <= sync.
- cnt==ON_CYC-1 -> OFF.
REQ-011 In OFF: oEmit=0 and cnt increments.
- cnt==ON_CYC+SAMPLE_AT-1 -> amb <= sync.
- cnt==FRAME_CYC-1 -> UPDATE.
REQ-012 UPDATE SHALL last exactly one cycle.
- det = lit & ~amb.
- oAmbErr <= amb.
- Debounce per REQ-014.
- oValid=1.
- Next state: ON with cnt=0 if en=1, else IDLE.
REQ-013 The frame period SHALL be FRAME_CYC+1 cycles, measured from ON entry to the next ON entry while en stays 1.
REQ-014 Debounce SHALL work per bit with a counter of width ceil(log2(DEB+1)).
- det bit == oLine bit -> counter cleared.
- Otherwise counter increments.
- Counter reaching DEB -> oLine bit <= det bit and counter cleared, in that UPDATE.
REQ-015 oLine and oAmbErr SHALL change only in UPDATE cycles.
REQ-016 oValid SHALL be high only in UPDATE, and exactly one cycle per frame.
REQ-017 en sampled only in IDLE and UPDATE: deasserting en mid-frame SHALL complete the frame including UPDATE and oValid, then go to IDLE.
REQ-018 Parameter legality SHALL be: SAMPLE_AT<ON_CYC, ON_CYC+SAMPLE_AT<FRAME_CYC, DEB>=1; illegal values are unsupported.
REQ-019 oEmit SHALL come directly from a flop, so it is glitch-free.

Reset
REQ-020 rst=1 SHALL immediately force state=IDLE and clear cnt, lit, amb, the synchronizer and the debounce counters.
REQ-021 rst=1 SHALL immediately set oEmit=0, oLine=0, oAmbErr=0, oValid=0, independent of clk.
REQ-022 Reset asserted mid-frame SHALL discard the partial frame; no oValid follows.
REQ-023 After release, the first frame SHALL start only once en=1 is seen in IDLE.

Verification (ON_CYC=20, SAMPLE_AT=15, FRAME_CYC=100, DEB=3)
REQ-024 Reset: rst=1 with en=1 -> all outputs 0 within the same cycle; release with en=0 -> oEmit stays 0 for 200 cycles.
REQ-025 Timing: en=1 from IDLE -> oEmit high exactly 20 cycles starting 1 cycle after en sampled; oValid pulses every 101 cycles.
REQ-026 Detect + debounce: iSens=5'b00100 whenever oEmit=1, else 0 (includes sync latency) -> oLine=0 at oValid #1 and #2, oLine=5'b00100 at oValid #3, oAmbErr=0 throughout.
REQ-027 Ambient: iSens held at 5'b11111 -> oAmbErr=5'b11111 at first oValid; oLine stays 0 for 10 frames.
REQ-028 Glitch rejection: det for bit C alternates 1/0 each frame -> oLine[2] never changes over 12 frames.
REQ-029 Mid-operation:
- en dropped at ON cycle 5 -> that frame still ends with one oValid, then oEmit stays 0.
- rst pulsed at OFF cycle 40 -> outputs clear, no oValid for the aborted frame.
